// File: rtl/frame_synch_pkg.sv
// Shared video timing constants for the frame synchroniser.
// Horizontal constants are in 7 MHz video cycles per line.
// Vertical constants are line numbers within a frame.
// The INT constants give the interrupt length in cend strobes.
package frame_synch_pkg;

  // Horizontal timing
  localparam int unsigned HPERIOD   = 448;
  localparam int unsigned HBLNK_BEG = 0;
  localparam int unsigned HSYNC_BEG = 16;
  localparam int unsigned HSYNC_END = 48;
  localparam int unsigned HBLNK_END = 96;

  // Vertical timing
  localparam int unsigned DEF_VPERIOD   = 320;
  localparam int unsigned DEF_VBLNK_BEG = 0;
  localparam int unsigned DEF_VSYNC_BEG = 8;
  localparam int unsigned DEF_VSYNC_END = 12;
  localparam int unsigned DEF_VBLNK_END = 32;
  localparam int unsigned DEF_VPIX_BEG  = 80;
  localparam int unsigned DEF_VPIX_END  = 272;

  // CPU interrupt
  localparam int unsigned DEF_INT_LINE = 0;
  localparam int unsigned DEF_INT_LEN  = 64;

  // Widths
  localparam int unsigned VCNT_W    = 9;
  localparam int unsigned INT_CNT_W = 7;

endpackage

// File: rtl/frame_synch_int_gen.sv
// int_gen: CPU interrupt pulse generator.
// A trig pulse starts an active-low pulse on int_n that lasts INT_LEN
// cend strobes. A trig that arrives while the pulse is running is ignored.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   cend   7 MHz working strobe, which paces the pulse length
//   trig   single-clk request to start the pulse
//   int_n  interrupt output, active low, registered
module int_gen
  import frame_synch_pkg::*;
#(
  parameter int unsigned INT_LEN = DEF_INT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cend,
  input  logic trig,
  output logic int_n
);

  localparam logic IDLE   = 1'b0;
  localparam logic ACTIVE = 1'b1;

  logic                 state;
  logic                 state_next;
  logic [INT_CNT_W-1:0] cnt;
  logic [INT_CNT_W-1:0] cnt_next;

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      int_n <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      int_n <= (state_next != ACTIVE);
    end
  end

  // Next state. The counter holds the number of cend strobes still to come
  // after the current one, so the pulse ends on the cend seen at zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (trig) begin
          state_next = ACTIVE;
          cnt_next   = INT_CNT_W'(INT_LEN - 1);
        end
      end
      ACTIVE: begin
        if (cend) begin
          if (cnt == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt - INT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/frame_synch.sv
// frame_synch: vertical frame timing.
// It counts lines on hsync_start, derives the vblank, vsync and vpix flags
// from line boundaries, marks the frame start, and triggers the CPU
// interrupt on the configured line.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cend         7 MHz working strobe
//   init         frame phase strobe; takes effect only with hsync_start
//   hsync_start  line advance pulse
//   line_start   pulse before the visible line start
//   hint_start   pulse at the horizontal INT position
//   vblank       vertical blank
//   vsync        vertical sync
//   vpix         vertical pixel gate
//   int_n        CPU interrupt, active low
//   frame_start  one-clk pulse on the first line_start of the frame
//   vcount       current line number
module frame_synch
  import frame_synch_pkg::*;
#(
  parameter int unsigned VPERIOD   = DEF_VPERIOD,
  parameter int unsigned VBLNK_BEG = DEF_VBLNK_BEG,
  parameter int unsigned VSYNC_BEG = DEF_VSYNC_BEG,
  parameter int unsigned VSYNC_END = DEF_VSYNC_END,
  parameter int unsigned VBLNK_END = DEF_VBLNK_END,
  parameter int unsigned VPIX_BEG  = DEF_VPIX_BEG,
  parameter int unsigned VPIX_END  = DEF_VPIX_END,
  parameter int unsigned INT_LINE  = DEF_INT_LINE,
  parameter int unsigned INT_LEN   = DEF_INT_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cend,
  input  logic              init,
  input  logic              hsync_start,
  input  logic              line_start,
  input  logic              hint_start,
  output logic              vblank,
  output logic              vsync,
  output logic              vpix,
  output logic              int_n,
  output logic              frame_start,
  output logic [VCNT_W-1:0] vcount
);

  logic [VCNT_W-1:0] vcount_next_c;
  logic              trig_c;

  // Line number that the next hsync_start will load
  always_comb begin
    vcount_next_c = vcount + VCNT_W'(1);
    if (init || (vcount == VCNT_W'(VPERIOD - 1))) begin
      vcount_next_c = '0;
    end
  end

  // The INT line compare uses the line number before any update in this clk
  assign trig_c = hint_start && (vcount == VCNT_W'(INT_LINE));

  // Line counter and flags; flags follow the new line number in the same clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcount      <= '0;
      vblank      <= 1'b1;
      vsync       <= 1'b0;
      vpix        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= line_start && (vcount == VCNT_W'(VBLNK_END));
      if (hsync_start) begin
        vcount <= vcount_next_c;

        if (vcount_next_c == VCNT_W'(VBLNK_BEG)) begin
          vblank <= 1'b1;
        end else if (vcount_next_c == VCNT_W'(VBLNK_END)) begin
          vblank <= 1'b0;
        end

        if (vcount_next_c == VCNT_W'(VSYNC_BEG)) begin
          vsync <= 1'b1;
        end else if (vcount_next_c == VCNT_W'(VSYNC_END)) begin
          vsync <= 1'b0;
        end

        if (vcount_next_c == VCNT_W'(VPIX_BEG)) begin
          vpix <= 1'b1;
        end else if (vcount_next_c == VCNT_W'(VPIX_END)) begin
          vpix <= 1'b0;
        end
      end
    end
  end

  int_gen #(
    .INT_LEN (INT_LEN)
  ) u_int_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .cend  (cend),
    .trig  (trig_c),
    .int_n (int_n)
  );

endmodule

// File: tb/tb_frame_synch.sv
// Self-checking bench for frame_synch with randomized cend and init.
// The reference model tracks the line number, the boundary-driven flags
// and the number of cend strobes left in the interrupt pulse.
module tb_frame_synch;

  localparam int LINE_CLK  = 64;
  localparam int LS_POS    = 40;
  localparam int M_VPERIOD = 320;
  localparam int M_VB_BEG  = 0;
  localparam int M_VS_BEG  = 8;
  localparam int M_VS_END  = 12;
  localparam int M_VB_END  = 32;
  localparam int M_VP_BEG  = 80;
  localparam int M_VP_END  = 272;
  localparam int M_INT_LN  = 0;
  localparam int M_INT_LEN = 64;

  logic       clk;
  logic       rst_n;
  logic       cend;
  logic       init;
  logic       hsync_start;
  logic       line_start;
  logic       hint_start;
  logic       vblank;
  logic       vsync;
  logic       vpix;
  logic       int_n;
  logic       frame_start;
  logic [8:0] vcount;

  int errors;
  int checks;

  int m_vc;
  int m_vblank;
  int m_vsync;
  int m_vpix;
  int m_fs;
  int m_rem;

  int width;
  int vsync_lines;
  int fs_count;
  bit rehint;
  bit init_req;

  frame_synch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cend        (cend),
    .init        (init),
    .hsync_start (hsync_start),
    .line_start  (line_start),
    .hint_start  (hint_start),
    .vblank      (vblank),
    .vsync       (vsync),
    .vpix        (vpix),
    .int_n       (int_n),
    .frame_start (frame_start),
    .vcount      (vcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vc     = 0;
    m_vblank = 1;
    m_vsync  = 0;
    m_vpix   = 0;
    m_fs     = 0;
    m_rem    = 0;
    width    = 0;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare just after
  task automatic tick(input logic hs, input logic ls, input logic hn,
                      input logic ini, input logic ce);
    bit pre_low;
    bit trig;
    int nv;
    int fs_n;
    @(negedge clk);
    hsync_start = hs;
    line_start  = ls;
    hint_start  = hn;
    init        = ini;
    cend        = ce;
    pre_low     = (int_n === 1'b0);
    @(posedge clk);
    trig = hn && (m_vc == M_INT_LN);
    fs_n = (ls && (m_vc == M_VB_END)) ? 1 : 0;
    if (hs) begin
      nv = (ini || (m_vc == M_VPERIOD - 1)) ? 0 : m_vc + 1;
      if (nv == M_VB_BEG) m_vblank = 1; else if (nv == M_VB_END) m_vblank = 0;
      if (nv == M_VS_BEG) m_vsync  = 1; else if (nv == M_VS_END) m_vsync  = 0;
      if (nv == M_VP_BEG) m_vpix   = 1; else if (nv == M_VP_END) m_vpix   = 0;
      m_vc = nv;
    end
    if (m_rem > 0) begin
      if (ce) m_rem--;
    end else if (trig) begin
      m_rem = M_INT_LEN;
    end
    m_fs = fs_n;
    #1;
    check("vcount", int'(vcount), m_vc);
    check("vblank", int'(vblank), m_vblank);
    check("vsync", int'(vsync), m_vsync);
    check("vpix", int'(vpix), m_vpix);
    check("frame_start", int'(frame_start), m_fs);
    check("int_n", int'(int_n), (m_rem == 0) ? 1 : 0);
    if (pre_low && ce) width++;
    if (pre_low && int_n === 1'b1) begin
      check("int_width", width, M_INT_LEN);
      width = 0;
    end
    if (hs && vsync === 1'b1) vsync_lines++;
    if (frame_start === 1'b1) fs_count++;
  endtask

  // Run clocks p_beg..p_end-1 of a line; phase 0 carries hsync_start
  task automatic run_line(input int hint_pos, input int p_beg, input int p_end);
    logic hn;
    logic ini;
    for (int p = p_beg; p < p_end; p++) begin
      hn = (p == hint_pos);
      if (rehint && width == 10 && int_n === 1'b0) begin
        hn     = 1'b1;
        rehint = 1'b0;
      end
      if (p == 0) begin
        ini      = init_req;
        init_req = 1'b0;
      end else begin
        ini = ($urandom_range(49) == 0);
      end
      tick(p == 0, p == LS_POS, hn, ini, $urandom_range(3) != 0);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    vsync_lines = 0;
    fs_count    = 0;
    rehint      = 1'b0;
    init_req    = 1'b0;
    rst_n       = 1'b0;
    cend        = 1'b0;
    init        = 1'b0;
    hsync_start = 1'b0;
    line_start  = 1'b0;
    hint_start  = 1'b0;
    model_reset();

    #12;
    check("rst_vcount", int'(vcount), 0);
    check("rst_vblank", int'(vblank), 1);
    check("rst_vsync", int'(vsync), 0);
    check("rst_vpix", int'(vpix), 0);
    check("rst_int_n", int'(int_n), 1);
    check("rst_frame_start", int'(frame_start), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame plus wrap; re-trigger 10 cend into the INT on line 0
    for (int i = 0; i < M_VPERIOD; i++) begin
      if (i == M_VPERIOD - 1) rehint = 1'b1;
      run_line(4, 0, LINE_CLK);
    end
    check("frame_vsync_lines", vsync_lines, 4);
    check("frame_start_count", fs_count, 1);
    check("wrap_vcount", int'(vcount), 0);

    // Advance to line 150, then init together with hsync_start
    for (int i = 0; i < 150; i++) run_line(4, 0, LINE_CLK);
    check("pre_init_vcount", int'(vcount), 150);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("init_vcount", int'(vcount), 0);
    check("init_vblank", int'(vblank), 1);
    run_line(4, 1, LINE_CLK);

    // hsync_start and hint_start together, line compare on pre-update line 0
    init_req = 1'b1;
    run_line(LINE_CLK, 0, LINE_CLK);
    run_line(0, 0, LINE_CLK);
    for (int i = 0; i < 4; i++) run_line(4, 0, LINE_CLK);

    // Asynchronous reset during an active INT
    init_req = 1'b1;
    run_line(4, 0, 20);
    check("int_active_before_rst", int'(int_n), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_int_n", int'(int_n), 1);
    check("async_rst_vcount", int'(vcount), 0);
    check("async_rst_vblank", int'(vblank), 1);
    check("async_rst_vsync", int'(vsync), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Counting restarts from line 0 after reset release
    vsync_lines = 0;
    fs_count    = 0;
    for (int i = 0; i < 40; i++) run_line(4, 0, LINE_CLK);
    check("post_rst_vcount", int'(vcount), 40);
    check("post_rst_vsync_lines", vsync_lines, 4);
    check("post_rst_frame_start", fs_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_synch.md
FRAME_SYNCH -- requirements
Module: frame_synch

Interface
REQ-001 The block SHALL have parameter VPERIOD, default 320, giving lines per frame.
REQ-002 The block SHALL have parameter VBLNK_BEG, default 0, giving the line where vblank sets.
REQ-003 The block SHALL have parameter VSYNC_BEG, default 8, giving the line where vsync sets.
REQ-004 The block SHALL have parameter VSYNC_END, default 12, giving the line where vsync clears.
REQ-005 The block SHALL have parameter VBLNK_END, default 32, giving the line where vblank clears.
REQ-006 The block SHALL have parameters VPIX_BEG, default 80, and VPIX_END, default 272, bounding the vertical pixel window.
REQ-007 The block SHALL have parameter INT_LINE, default 0, giving the line carrying the INT start.
REQ-008 The block SHALL have parameter INT_LEN, default 64, giving INT width in cend cycles.
REQ-009 clk  in  1  system clock; all logic on posedge.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 cend  in  1  7 MHz working strobe.
REQ-012 init  in  1  frame phase strobe, sampled on hsync_start.
REQ-013 hsync_start  in  1  single-clk pulse, one video cycle before line hsync.
REQ-014 line_start  in  1  single-clk pulse before visible line start.
REQ-015 hint_start  in  1  single-clk pulse at the horizontal INT position.
REQ-016 vblank  out  1  vertical blank.
REQ-017 vsync  out  1  vertical sync.
REQ-018 vpix  out  1  vertical pixel gate.
REQ-019 int_n  out  1  CPU interrupt, active low.
REQ-020 frame_start  out  1  single-clk pulse on the first line_start of the frame.
REQ-021 vcount  out  9  current line number.

Function
REQ-022 vcount SHALL update only on clk edges with hsync_start=1: to 0 if init=1 or vcount==VPERIOD-1, else to vcount+1.
REQ-023 vblank SHALL set on the hsync_start edge where the new vcount equals VBLNK_BEG, and clear where it equals VBLNK_END; vsync SHALL use VSYNC_BEG/VSYNC_END the same way; vpix SHALL use VPIX_BEG/VPIX_END the same way. All three SHALL change in the same cycle as vcount, with no additional latency.
REQ-024 frame_start SHALL pulse high for exactly one clk, one clk after a line_start with vcount==VBLNK_END, and SHALL otherwise be 0.
REQ-025 The INT FSM SHALL have two states, IDLE and ACTIVE. IDLE moves to ACTIVE one clk after hint_start=1 with vcount==INT_LINE; int_n SHALL be 0 exactly while ACTIVE.
REQ-026 On entering ACTIVE, the FSM SHALL load a 7-bit counter with INT_LEN-1. Each cend in ACTIVE SHALL decrement the counter; cend with counter==0 SHALL return the FSM to IDLE. int_n low therefore spans exactly INT_LEN cend strobes.
REQ-027 hint_start arriving while ACTIVE SHALL be ignored; it SHALL neither restart nor extend the pulse.
REQ-028 hsync_start and hint_start in the same clk SHALL both be processed. The INT line compare SHALL use the pre-update vcount.
REQ-029 init SHALL NOT abort an ACTIVE INT; flag outputs SHALL be re-evaluated against vcount=0 as in REQ-023.
REQ-030 An init that does not coincide with hsync_start SHALL be ignored.
REQ-031 When vcount wraps from VPERIOD-1 to 0, the block SHALL treat line 0 as any other line; no pulse SHALL be lost or duplicated.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force: vcount=0, vblank=1, vsync=0, vpix=0, int_n=1, frame_start=0, FSM=IDLE, counter=0.
REQ-033 Reset deassertion mid-frame SHALL restart counting from line 0 on the next hsync_start (0→1).
REQ-034 A reset during ACTIVE SHALL end INT immediately, with int_n=1.

Structure
REQ-035 The default line constants and INT_LEN SHALL live in the shared video timing package, alongside the horizontal timing constants.
REQ-036 The INT FSM and counter SHALL be one sub-module, int_gen, with inputs clk, rst_n, cend, trig and output int_n.
REQ-037 The top level SHALL contain only the line counter and the flag registers.

Verification
REQ-038 Drive 320 hsync_start pulses, 448 cend apart -> vcount runs 0..319 then returns to 0; vsync is high for exactly lines 8..11.
REQ-039 Drive hint_start with vcount==0 -> int_n falls one clk later and stays low for exactly 64 cend strobes.
REQ-040 Drive a second hint_start 10 cend into the INT -> pulse width is still 64 cend.
REQ-041 Drive init together with hsync_start at vcount=150 -> vcount=0 and vblank=1 in the next cycle.
REQ-042 Drop rst_n during an active INT -> int_n=1 and vcount=0 immediately, without waiting for a clock edge.
REQ-043 Drive line_start at vcount==32 -> frame_start is a one-clk pulse, asserted once per frame.
